// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier (signed/unsigned) producing a 2*WIDTH product on hi/lo.
// Latency: WIDTH+1 cycles from accepted start to the done pulse; one multiply in flight.
// Backpressure: start_mult is ignored while busy; the caller holds it off until IDLE/DONE.
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             mult_sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, next_state;

    // acc[2W] carry, acc[2W-1:W] partial product, acc[W-1:0] remaining multiplier bits
    logic [2*WIDTH:0]   acc;
    logic [WIDTH-1:0]   mcand;
    logic               neg;
    logic [CW-1:0]      counter;

    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH:0]   added;
    logic [2*WIDTH:0]   step;
    logic [2*WIDTH-1:0] prod_final;

    // Operand magnitudes and one shift-add step of the accumulator
    always_comb begin
        a_mag = a;
        b_mag = b;
        if (mult_sign && a[WIDTH-1]) a_mag = ~a + WIDTH'(1);
        if (mult_sign && b[WIDTH-1]) b_mag = ~b + WIDTH'(1);

        // acc[2W] is always zero between steps, so this add cannot overflow W+1 bits
        sum   = acc[2*WIDTH:WIDTH] + {1'b0, mcand};
        added = acc[0] ? {sum, acc[WIDTH-1:0]} : acc;
        step  = added >> 1;

        // The last step result goes straight to hi/lo, negated if the signs differed
        prod_final = step[2*WIDTH-1:0];
        if (neg) prod_final = ~step[2*WIDTH-1:0] + (2*WIDTH)'(1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    // Next-state decode and status outputs
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            S_IDLE: begin
                accept = start_mult;
                if (start_mult) next_state = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                last = (counter == CW'(WIDTH - 1));
                if (last) next_state = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                accept     = start_mult;
                next_state = start_mult ? S_RUN : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate in RUN, publish hi/lo on the final step only
    always_ff @(posedge clk) begin
        if (reset) begin
            acc     <= '0;
            mcand   <= '0;
            neg     <= 1'b0;
            counter <= '0;
            hi      <= '0;
            lo      <= '0;
        end else if (accept) begin
            mcand   <= a_mag;
            acc     <= {1'b0, {WIDTH{1'b0}}, b_mag};
            neg     <= mult_sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            counter <= '0;
        end else if (state == S_RUN) begin
            acc     <= step;
            counter <= counter + CW'(1);
            if (last) begin
                hi <= prod_final[2*WIDTH-1:WIDTH];
                lo <= prod_final[WIDTH-1:0];
            end
        end
    end

endmodule
